// File: rtl/lsu.sv
// Load/store unit: CPU-side initiator of the data-memory interface.
// Accepts one load/store op from execute, validates it, drives dmem_* until
// dmem_drdy (or timeout), extends load data and hands a result to writeback.
// Only one op is in flight at a time.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   op_valid/op_ready    op handshake from execute (ready only in idle)
//   op_load/op_store     op kind; exactly one must be set
//   op_funct3            RV32 size/sign (B, H, W, BU, HU)
//   op_addr/op_wdata     effective byte address and store data
//   op_rd                destination tag, echoed on res_rd
//   res_valid/res_ready  result handshake to writeback
//   res_data/res_rd      extended load data (0 for stores/errors) and tag
//   res_err              00 ok, 01 misaligned, 10 timeout, 11 illegal
//   dmem_*               memory request (driven only while accessing)
//   dmem_drdy/dmem_rdata memory completion strobe and read word
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        op_load,
  input  logic        op_store,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [4:0]  op_rd,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic [1:0]  res_err,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        dmem_rdu,
  output logic        dmem_hwrd,
  output logic        dmem_wrd,
  input  logic        dmem_drdy,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrMisal   = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;
  localparam logic [1:0] ErrIllegal = 2'b11;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load_q;
  logic [2:0]      funct3_q;
  logic [31:0]     addr_q, wdata_q;
  logic [31:0]     res_data_q, res_data_d;
  logic [4:0]      res_rd_q, res_rd_d;
  logic [1:0]      res_err_q, res_err_d;
  logic            op_take;

  // Decode of the op presented in idle
  logic f3_ok, op_legal, op_misal;
  always_comb begin
    unique case (op_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = op_load;  // unsigned forms exist only for loads
      default:                f3_ok = 1'b0;
    endcase
    op_legal = (op_load != op_store) && f3_ok;
    op_misal = ((op_funct3[1:0] == 2'b01) && op_addr[0]) ||
               ((op_funct3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
  end

  // Load extraction; rdata carries the addressed byte in [7:0]
  logic [31:0] load_ext;
  always_comb begin
    unique case (funct3_q)
      3'b000:  load_ext = {{24{dmem_rdata[7]}}, dmem_rdata[7:0]};
      3'b100:  load_ext = {24'd0, dmem_rdata[7:0]};
      3'b001:  load_ext = {{16{dmem_rdata[15]}}, dmem_rdata[15:0]};
      3'b101:  load_ext = {16'd0, dmem_rdata[15:0]};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    res_err_d  = res_err_q;
    op_take    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          op_take    = 1'b1;
          res_rd_d   = op_rd;
          res_data_d = '0;
          res_err_d  = ErrOk;
          if (!op_legal) begin
            res_err_d = ErrIllegal;
            state_d   = StResp;
          end else if (op_misal) begin
            res_err_d = ErrMisal;
            state_d   = StResp;
          end else begin
            state_d = StAccess;
          end
        end
      end
      StAccess: begin
        if (dmem_drdy) begin
          res_data_d = load_q ? load_ext : '0;
          res_err_d  = ErrOk;
          cnt_d      = '0;
          state_d    = StResp;
        end else if (cnt_q == CntLast) begin
          res_data_d = '0;
          res_err_d  = ErrTimeout;
          cnt_d      = '0;
          state_d    = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp: begin
        if (res_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_rd_q   <= '0;
      res_err_q  <= '0;
      load_q     <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      res_err_q  <= res_err_d;
      if (op_take) begin
        load_q   <= op_load;
        funct3_q <= op_funct3;
        addr_q   <= op_addr;
        wdata_q  <= op_wdata;
      end
    end
  end

  // Memory request is gated by state so it collapses at once on async reset
  logic in_access;
  always_comb begin
    in_access  = (state_q == StAccess);
    dmem_addr  = in_access ? addr_q : '0;
    dmem_wdata = in_access ? wdata_q : '0;
    dmem_read  = in_access && load_q;
    dmem_write = in_access && !load_q;
    dmem_hwrd  = in_access && (funct3_q[1:0] == 2'b01);
    dmem_wrd   = in_access && (funct3_q == 3'b010);
    dmem_rdu   = in_access && funct3_q[2];
    op_ready   = (state_q == StIdle);
    res_valid  = (state_q == StResp);
    res_data   = res_data_q;
    res_rd     = res_rd_q;
    res_err    = res_err_q;
  end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
  localparam int TO = 4;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        op_valid = 0, op_ready, op_load = 0, op_store = 0;
  logic [2:0]  op_funct3 = 0;
  logic [31:0] op_addr = 0, op_wdata = 0;
  logic [4:0]  op_rd = 0;
  logic        res_valid, res_ready = 0;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic [1:0]  res_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_read, dmem_write, dmem_rdu, dmem_hwrd, dmem_wrd, dmem_drdy;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_load(op_load), .op_store(op_store), .op_funct3(op_funct3), .op_addr(op_addr),
    .op_wdata(op_wdata), .op_rd(op_rd), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd), .res_err(res_err), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_rdu(dmem_rdu), .dmem_hwrd(dmem_hwrd), .dmem_wrd(dmem_wrd),
    .dmem_drdy(dmem_drdy), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Simple memory responder: drdy after drdy_delay request cycles
  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  int drdy_delay = 0;
  int acc_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_cnt <= 0;
    else if (!(dmem_read || dmem_write)) acc_cnt <= 0;
    else acc_cnt <= acc_cnt + 1;
  end

  assign dmem_drdy = (dmem_read || dmem_write) && (acc_cnt == drdy_delay);
  assign dmem_rdata = {mem[8'(dmem_addr[7:0] + 8'd3)], mem[8'(dmem_addr[7:0] + 8'd2)],
                       mem[8'(dmem_addr[7:0] + 8'd1)], mem[dmem_addr[7:0]]};

  always @(posedge clk) begin
    if (dmem_write && dmem_drdy) begin
      mem[dmem_addr[7:0]] <= dmem_wdata[7:0];
      if (dmem_hwrd || dmem_wrd) mem[8'(dmem_addr[7:0] + 8'd1)] <= dmem_wdata[15:8];
      if (dmem_wrd) begin
        mem[8'(dmem_addr[7:0] + 8'd2)] <= dmem_wdata[23:16];
        mem[8'(dmem_addr[7:0] + 8'd3)] <= dmem_wdata[31:24];
      end
    end
  end

  // One op end to end; expectations come from the reference memory and op rules
  task automatic do_op(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int dly, input int hold, output logic [31:0] got);
    int size, acc, exp_acc;
    bit legal, misal, first;
    logic [31:0] exp_data, a0;
    logic [1:0] exp_err;
    logic [4:0] rd;
    logic [31:0] h_data;
    logic [1:0] h_err;
    logic [4:0] h_rd;

    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    legal = (ld != st) && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
                           (ld && (f3 == 3'd4 || f3 == 3'd5)));
    misal = (f3[1:0] != 2'b11) && ((addr % size) != 0);
    exp_data = 0;
    if (!legal) begin
      exp_err = 2'b11; exp_acc = 0;
    end else if (misal) begin
      exp_err = 2'b01; exp_acc = 0;
    end else if (dly >= TO) begin
      exp_err = 2'b10; exp_acc = TO;
    end else begin
      exp_err = 2'b00; exp_acc = dly + 1;
      for (int k = 0; k < size; k++) begin
        if (ld) exp_data |= 32'(ref_mem[8'(addr + k)]) << (8 * k);
        else ref_mem[8'(addr + k)] = wdata[8*k +: 8];
      end
      if (ld && !f3[2] && size == 1 && exp_data[7])  exp_data |= 32'hFFFF_FF00;
      if (ld && !f3[2] && size == 2 && exp_data[15]) exp_data |= 32'hFFFF_0000;
    end

    rd = 5'($urandom);
    drdy_delay = dly;
    @(negedge clk);
    check_eq("op_ready_idle", 32'(op_ready), 1);
    op_valid = 1; op_load = ld; op_store = st; op_funct3 = f3;
    op_addr = addr; op_wdata = wdata; op_rd = rd;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must be ignored
    op_valid = 0; op_load = 1'($urandom); op_store = 1'($urandom);
    op_funct3 = 3'($urandom); op_addr = $urandom; op_wdata = $urandom; op_rd = 5'($urandom);

    acc = 0; first = 1; a0 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (res_valid) break;
      if (dmem_read || dmem_write) begin
        acc++;
        if (first) begin
          a0 = dmem_addr; first = 0;
          check_eq("dmem_addr", a0, addr);
          check_eq("dmem_rw", {dmem_read, dmem_write}, {ld, st});
          check_eq("dmem_qual", {dmem_rdu, dmem_hwrd, dmem_wrd},
                   {f3[2], size == 2, size == 4});
          if (st) check_eq("dmem_wdata", dmem_wdata, wdata);
        end else begin
          check_eq("dmem_addr_stable", dmem_addr, a0);
        end
      end
    end
    check_eq("res_valid", 32'(res_valid), 1);
    check_eq("access_cycles", acc, exp_acc);
    check_eq("dmem_idle_in_resp", {dmem_read, dmem_write}, 0);
    check_eq("res_err", 32'(res_err), 32'(exp_err));
    check_eq("res_data", res_data, exp_data);
    check_eq("res_rd", 32'(res_rd), 32'(rd));
    got = res_data;
    h_data = res_data; h_err = res_err; h_rd = res_rd;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq("hold_stable", {res_valid, op_ready, res_err, res_rd, res_data},
               {1'b1, 1'b0, h_err, h_rd, h_data});
    end
    res_ready = 1;
    @(posedge clk); #1;
    res_ready = 0;
    check_eq("back_to_idle", {res_valid, op_ready}, 2'b01);
  endtask

  logic [31:0] r;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #12;
    check_eq("rst_outputs", {op_ready, res_valid, res_err, res_rd, dmem_read, dmem_write,
                             dmem_rdu, dmem_hwrd, dmem_wrd}, {1'b1, 13'd0});
    check_eq("rst_res_data", res_data, 0);
    check_eq("rst_dmem_addr", dmem_addr, 0);
    @(negedge clk); rst_n = 1;

    // Directed
    do_op(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, r);
    do_op(1, 0, 3'b010, 32'h10, 0, 0, 0, r);
    check_eq("lw_deadbeef", r, 32'hDEADBEEF);
    do_op(0, 1, 3'b010, 32'h20, 32'h0000_80F0, 0, 0, r);
    do_op(1, 0, 3'b000, 32'h20, 0, 0, 0, r); check_eq("lb", r, 32'hFFFF_FFF0);
    do_op(1, 0, 3'b100, 32'h20, 0, 1, 0, r); check_eq("lbu", r, 32'h0000_00F0);
    do_op(1, 0, 3'b001, 32'h20, 0, 2, 0, r); check_eq("lh", r, 32'hFFFF_80F0);
    do_op(1, 0, 3'b101, 32'h20, 0, 3, 0, r); check_eq("lhu", r, 32'h0000_80F0);
    do_op(1, 0, 3'b001, 32'h21, 0, 0, 0, r);
    do_op(1, 0, 3'b010, 32'h22, 0, 0, 0, r);
    do_op(1, 0, 3'b010, 32'h20, 0, 50, 0, r);
    do_op(1, 1, 3'b010, 32'h20, 0, 0, 0, r);
    do_op(0, 1, 3'b100, 32'h20, 0, 0, 5, r);
    do_op(0, 0, 3'b000, 32'h20, 0, 0, 0, r);
    do_op(1, 0, 3'b011, 32'h20, 0, 0, 2, r);

    // Reset in the middle of a stalled store: nothing may be committed
    drdy_delay = 1000;
    @(negedge clk);
    op_valid = 1; op_load = 0; op_store = 1; op_funct3 = 3'b010;
    op_addr = 32'h40; op_wdata = 32'hA5A5_5A5A;
    @(posedge clk); #1; op_valid = 0;
    @(negedge clk);
    check_eq("write_before_rst", 32'(dmem_write), 1);
    #2 rst_n = 0;
    #1;
    check_eq("write_drops_async", 32'(dmem_write), 0);
    check_eq("rst_mid_outputs", {op_ready, res_valid, res_err, dmem_read, dmem_addr},
             {1'b1, 1'b0, 2'b00, 1'b0, 32'd0});
    @(negedge clk); rst_n = 1;
    do_op(1, 0, 3'b010, 32'h40, 0, 0, 0, r);

    // Randomized ops against the reference model
    for (int n = 0; n < 80; n++) begin
      logic ld, st;
      logic [2:0] f3;
      logic [31:0] addr;
      int sel;
      sel = $urandom_range(0, 19);
      ld = $urandom_range(0, 1);
      st = (sel == 0) ? ld : !ld;
      f3 = (sel == 1) ? 3'($urandom) : (ld ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 2)));
      if (ld && f3 == 3'd3) f3 = 3'd5;
      addr = 32'($urandom_range(0, 251));
      if (sel > 3) addr = addr & ~32'((f3[1:0] == 2'b10) ? 3 : (f3[1:0] == 2'b01) ? 1 : 0);
      do_op(ld, st, f3, addr, $urandom, (sel == 2) ? TO + 1 : $urandom_range(0, 3),
            $urandom_range(0, 2), r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
